prog_loader: RTL

Writer side of the core's instruction-fetch path: a byte-stream program loader that owns an 8-bit-wide program RAM, fills it from a valid/ready byte source, and serves the core's combinational fetch (`pc` in, instruction out) in place of the fixed ROM. While a load is in progress or has failed, the loader holds the core in reset. On a good checksum it releases the core to run from address 0.

---
 rtl/prog_loader_pkg.sv | 30 +++
 rtl/prog_ram.sv | 24 ++
 rtl/prog_loader.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and defaults for the program loader: FSM states, geometry defaults, checksum helpers.
package prog_loader_pkg;

  localparam int unsigned DEF_DEPTH   = 256;
  localparam int unsigned DEF_AW      = 8;
  localparam int unsigned DEF_TIMEOUT = 1000;
  localparam int unsigned CSUM_W      = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_SUM,
    ST_RUN,
    ST_ERR
  } state_t;

  typedef logic [CSUM_W-1:0] csum_t;

  // Modulo-256 running sum of the data bytes.
  function automatic csum_t csum_add(input csum_t acc, input logic [7:0] b);
    return acc + b;
  endfunction

  // States in which the loader is waiting for stream bytes.
  function automatic logic is_loading(input state_t s);
    return (s == ST_LEN) || (s == ST_DATA) || (s == ST_SUM);
  endfunction

endpackage

// File: rtl/prog_ram.sv
// Program RAM: DEPTH x 8 storage, one synchronous write port, one asynchronous read port, no reset.
module prog_ram
  import prog_loader_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = DEF_AW
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: LEN / data / SUM frame into program RAM, holds the core until a good checksum.
// Optional per-byte idle timeout enabled by defining PROG_LOADER_TIMEOUT_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic       clk,
  input  logic       CLB,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] pc,
  output logic [7:0] ins,
  output logic       core_hold,
  output logic       load_done,
  output logic       load_err
);

  // Counter is one bit wider than the RAM address so a full-depth frame can terminate.
  localparam int unsigned LW = AW + 1;

  if (DEPTH > 256 || (32'd1 << AW) != DEPTH || TIMEOUT == 0) begin : g_bad_cfg
    $error("prog_loader: unsupported DEPTH/AW/TIMEOUT combination");
  end

  state_t        r_state, w_state_nxt;
  logic [LW-1:0] r_addr, w_addr_nxt, w_addr_inc;
  logic [LW-1:0] r_len, w_len_nxt;
  csum_t         r_acc, w_acc_nxt;
  logic          w_accept;
  logic          w_we;
  logic          w_timeout;
  logic          r_in_ready, w_in_ready_nxt;
  logic          r_core_hold, w_core_hold_nxt;
  logic          r_load_done, w_load_done_nxt;
  logic          r_load_err, w_load_err_nxt;

  assign w_accept   = in_valid && r_in_ready;
  assign w_addr_inc = r_addr + 1'b1;

`ifdef PROG_LOADER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_idle, w_idle_nxt;

  assign w_timeout = is_loading(r_state) && !w_accept && (r_idle == TW'(TIMEOUT - 1));

  // Idle count restarts on every accepted byte, every restart and every state change.
  always_comb begin
    w_idle_nxt = '0;
    if (!start && !w_accept && is_loading(r_state) && (w_state_nxt == r_state))
      w_idle_nxt = r_idle + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (CLB) r_idle <= '0;
    else     r_idle <= w_idle_nxt;
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (CLB) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_acc       <= '0;
      r_in_ready  <= 1'b0;
      r_core_hold <= 1'b1;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_len       <= w_len_nxt;
      r_acc       <= w_acc_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_core_hold <= w_core_hold_nxt;
      r_load_done <= w_load_done_nxt;
      r_load_err  <= w_load_err_nxt;
    end
  end

  // Next state, datapath updates and registered-output next values.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_len_nxt   = r_len;
    w_acc_nxt   = r_acc;
    w_we        = 1'b0;

    if (start) begin
      // Restart wins over a same-cycle byte: it is consumed but never written.
      w_state_nxt = ST_LEN;
      w_addr_nxt  = '0;
      w_acc_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_RUN, ST_ERR: ;
        ST_LEN: begin
          if (w_accept) begin
            w_addr_nxt = '0;
            w_acc_nxt  = '0;
            if ({1'b0, in_data} > 9'(DEPTH)) begin
              w_state_nxt = ST_ERR;
            end else begin
              w_len_nxt   = (in_data == 8'd0) ? LW'(DEPTH) : LW'(in_data);
              w_state_nxt = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_accept) begin
            w_we       = 1'b1;
            w_addr_nxt = w_addr_inc;
            w_acc_nxt  = csum_add(r_acc, in_data);
            if (w_addr_inc == r_len) w_state_nxt = ST_SUM;
          end
        end
        ST_SUM: begin
          if (w_accept) w_state_nxt = (in_data == r_acc) ? ST_RUN : ST_ERR;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
      if (w_timeout) w_state_nxt = ST_ERR;
    end

    w_in_ready_nxt  = is_loading(w_state_nxt);
    w_core_hold_nxt = (w_state_nxt != ST_RUN);
    w_load_done_nxt = (w_state_nxt == ST_RUN) && (r_state != ST_RUN);
    w_load_err_nxt  = (w_state_nxt == ST_ERR);
  end

  prog_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we && !CLB),
    .i_waddr (r_addr[AW-1:0]),
    .i_wdata (in_data),
    .i_raddr (pc[AW-1:0]),
    .o_rdata (ins)
  );

  assign in_ready  = r_in_ready;
  assign core_hold = r_core_hold;
  assign load_done = r_load_done;
  assign load_err  = r_load_err;

endmodule
